// File: rtl/adaptive_clock_tuner.sv
// Binary search for the smallest clock divider that survives a validation window,
// with guard band, one-shot/tracking modes and a failure indication.
module adaptive_clock_tuner #(
  parameter int DATA_WIDTH        = 8,
  parameter int INITIAL_CLK_DIV   = 128,
  parameter int MIN_CLK_DIV       = 1,
  parameter int MAX_CLK_DIV       = 254,
  parameter int SETTLE_CYCLES     = 4,
  parameter int VALIDATION_CYCLES = 16,
  parameter int GUARD_BAND        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_Start,
  input  logic                  i_Mode,
  input  logic                  i_Error_Flag,
  output logic [DATA_WIDTH-1:0] o_Clk_Div,
  output logic                  o_Div_Update,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Fail
);

  // state   | meaning
  // IDLE    | waiting for i_Start, initial divider applied
  // APPLY   | drive midpoint candidate
  // SETTLE  | let the new divider settle, errors ignored
  // OBSERVE | count consecutive error-free cycles
  // UPDATE  | narrow the search range or finish
  // DONE    | converged; tracking mode re-arms on error
  // FAIL    | no candidate passed, held until reset

  localparam int PW = $clog2(VALIDATION_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] INIT_V = DATA_WIDTH'(INITIAL_CLK_DIV);
  localparam logic [DATA_WIDTH-1:0] MIN_V  = DATA_WIDTH'(MIN_CLK_DIV);
  localparam logic [DATA_WIDTH-1:0] MAX_V  = DATA_WIDTH'(MAX_CLK_DIV);
  localparam logic [PW-1:0] PASS_LAST      = PW'(VALIDATION_CYCLES - 1);
  localparam logic [PW-1:0] PASS_FULL      = PW'(VALIDATION_CYCLES);
  localparam logic [SW-1:0] SETTLE_LOAD    = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_OBSERVE, S_UPDATE, S_DONE, S_FAIL
  } state_t;

  state_t                state, state_nxt;
  logic                  mode, mode_nxt;
  logic [DATA_WIDTH-1:0] low, low_nxt, high, high_nxt, mid, mid_nxt;
  logic [DATA_WIDTH-1:0] best, best_nxt, div_nxt, final_div;
  logic                  best_valid, best_valid_nxt, passed, passed_nxt, search_end;
  logic [SW-1:0]         settle_cnt, settle_nxt;
  logic [PW-1:0]         pass_cnt, pass_nxt;
  logic                  upd_nxt, busy_nxt, done_nxt, fail_nxt;
  logic [DATA_WIDTH:0]   mid_sum, guard_sum, rearm_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mode         <= 1'b0;
      low          <= MIN_V;
      high         <= MAX_V;
      mid          <= INIT_V;
      best         <= '0;
      best_valid   <= 1'b0;
      passed       <= 1'b0;
      settle_cnt   <= '0;
      pass_cnt     <= '0;
      o_Clk_Div    <= INIT_V;
      o_Div_Update <= 1'b0;
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
      o_Fail       <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      low          <= low_nxt;
      high         <= high_nxt;
      mid          <= mid_nxt;
      best         <= best_nxt;
      best_valid   <= best_valid_nxt;
      passed       <= passed_nxt;
      settle_cnt   <= settle_nxt;
      pass_cnt     <= pass_nxt;
      o_Clk_Div    <= div_nxt;
      o_Div_Update <= upd_nxt;
      o_Busy       <= busy_nxt;
      o_Done       <= done_nxt;
      o_Fail       <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode;
    low_nxt        = low;
    high_nxt       = high;
    mid_nxt        = mid;
    best_nxt       = best;
    best_valid_nxt = best_valid;
    passed_nxt     = passed;
    settle_nxt     = settle_cnt;
    pass_nxt       = pass_cnt;
    div_nxt        = o_Clk_Div;
    upd_nxt        = 1'b0;
    busy_nxt       = o_Busy;
    done_nxt       = o_Done;
    fail_nxt       = o_Fail;
    search_end     = 1'b0;
    final_div      = MAX_V;
    mid_sum        = {1'b0, low} + {1'b0, high};
    guard_sum      = '0;
    rearm_sum      = {1'b0, o_Clk_Div} + (DATA_WIDTH + 1)'(1);

    case (state)
      S_IDLE: begin
        if (i_Start) begin
          mode_nxt       = i_Mode;
          low_nxt        = MIN_V;
          high_nxt       = MAX_V;
          best_valid_nxt = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = S_APPLY;
        end
      end
      S_APPLY: begin
        mid_nxt    = DATA_WIDTH'(mid_sum >> 1);
        div_nxt    = mid_nxt;
        upd_nxt    = (mid_nxt != o_Clk_Div);
        settle_nxt = SETTLE_LOAD;
        state_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          pass_nxt  = '0;
          state_nxt = S_OBSERVE;
        end else begin
          settle_nxt = settle_cnt - 1'b1;
        end
      end
      S_OBSERVE: begin
        // an error on the final counted cycle still fails the candidate
        if (i_Error_Flag) begin
          passed_nxt = 1'b0;
          state_nxt  = S_UPDATE;
        end else if (pass_cnt == PASS_LAST) begin
          pass_nxt   = PASS_FULL;
          passed_nxt = 1'b1;
          state_nxt  = S_UPDATE;
        end else begin
          pass_nxt = pass_cnt + 1'b1;
        end
      end
      S_UPDATE: begin
        if (passed) begin
          best_nxt       = mid;
          best_valid_nxt = 1'b1;
          if (mid == MIN_V) search_end = 1'b1;
          else              high_nxt   = mid - 1'b1;
        end else begin
          if (mid == MAX_V) search_end = 1'b1;
          else              low_nxt    = mid + 1'b1;
        end
        if (search_end || (low_nxt > high_nxt)) begin
          guard_sum = {1'b0, best_nxt} + (DATA_WIDTH + 1)'(GUARD_BAND);
          if (best_valid_nxt)
            final_div = (guard_sum > {1'b0, MAX_V}) ? MAX_V : guard_sum[DATA_WIDTH-1:0];
          div_nxt   = final_div;
          upd_nxt   = (final_div != o_Clk_Div);
          busy_nxt  = 1'b0;
          done_nxt  = best_valid_nxt;
          fail_nxt  = !best_valid_nxt;
          state_nxt = best_valid_nxt ? S_DONE : S_FAIL;
        end else begin
          state_nxt = S_APPLY;
        end
      end
      S_DONE: begin
        if (mode && i_Error_Flag) begin
          done_nxt = 1'b0;
          if (o_Clk_Div == MAX_V) begin
            fail_nxt  = 1'b1;
            state_nxt = S_FAIL;
          end else begin
            low_nxt        = (rearm_sum > {1'b0, MAX_V}) ? MAX_V : rearm_sum[DATA_WIDTH-1:0];
            high_nxt       = MAX_V;
            best_valid_nxt = 1'b0;
            busy_nxt       = 1'b1;
            state_nxt      = S_APPLY;
          end
        end
      end
      S_FAIL: ;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adaptive_clock_tuner.sv
// Directed bench for adaptive_clock_tuner: an error model fails any divider below a
// threshold, with optional error injection relative to each divider change.
module tb_adaptive_clock_tuner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Mode = 1'b0;
  logic       i_Error_Flag = 1'b0;
  logic [7:0] o_Clk_Div;
  logic       o_Div_Update, o_Busy, o_Done, o_Fail;

  int checks = 0;
  int errors = 0;
  int thr = 0;
  bit inj_settle = 0;
  bit inj_obs16 = 0;
  int k = -1;
  int cand = 0;
  int upd_cnt = 0;

  adaptive_clock_tuner dut (
    .clk(clk), .rst_n(rst_n), .i_Start(i_Start), .i_Mode(i_Mode),
    .i_Error_Flag(i_Error_Flag), .o_Clk_Div(o_Clk_Div), .o_Div_Update(o_Div_Update),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Fail(o_Fail)
  );

  always #5 clk = ~clk;

  // k counts negedges since the last divider change; the flag driven at k reaches edge k+2
  always @(negedge clk) begin
    logic err;
    if (!rst_n) begin
      k = -1; cand = 0; upd_cnt = 0;
    end else if (o_Div_Update) begin
      k = 0; cand++;
      if (!o_Done && !o_Fail) upd_cnt++;
    end else if (k >= 0) begin
      k++;
    end
    err = (int'(o_Clk_Div) < thr);
    if (inj_settle && k >= 0 && k < 4) err = 1'b1;
    if (inj_obs16 && cand == 1 && k == 19) err = 1'b1;
    i_Error_Flag = err;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    i_Mode = m; i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0; i_Mode = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(o_Done || o_Fail) && n < 800) begin
      @(negedge clk); n++;
    end
    chk({tag, "_timeout"}, int'(n < 800), 1);
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_div", o_Clk_Div, 128);
    chk("rst_upd", o_Div_Update, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_fail", o_Fail, 0);

    // threshold 40, one-shot
    thr = 40;
    pulse_start(1'b0);
    @(negedge clk);
    chk("t1_busy", o_Busy, 1);
    wait_end("t1");
    chk("t1_done", o_Done, 1);
    chk("t1_fail", o_Fail, 0);
    chk("t1_busy_low", o_Busy, 0);
    chk("t1_div", o_Clk_Div, 42);
    chk("t1_updates", upd_cnt, 8);
    pulse_start(1'b1);
    thr = 60;
    repeat (6) @(negedge clk);
    chk("t1_hold_div", o_Clk_Div, 42);
    chk("t1_hold_done", o_Done, 1);
    chk("t1_hold_busy", o_Busy, 0);

    // always erring
    do_reset();
    thr = 255;
    pulse_start(1'b0);
    wait_end("t2");
    chk("t2_fail", o_Fail, 1);
    chk("t2_done", o_Done, 0);
    chk("t2_div", o_Clk_Div, 254);
    chk("t2_busy", o_Busy, 0);
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    chk("t2_start_ignored", o_Busy, 0);
    chk("t2_fail_hold", o_Fail, 1);

    // never erring
    do_reset();
    thr = 0;
    pulse_start(1'b0);
    wait_end("t3");
    chk("t3_done", o_Done, 1);
    chk("t3_div", o_Clk_Div, 3);

    // errors only inside settle windows
    do_reset();
    thr = 40; inj_settle = 1;
    pulse_start(1'b0);
    wait_end("t4");
    inj_settle = 0;
    chk("t4_done", o_Done, 1);
    chk("t4_div", o_Clk_Div, 42);

    // single error on the 16th observe cycle of the first candidate (127)
    do_reset();
    thr = 40; inj_obs16 = 1;
    pulse_start(1'b0);
    wait_end("t5");
    inj_obs16 = 0;
    chk("t5_done", o_Done, 1);
    chk("t5_div", o_Clk_Div, 130);

    // tracking mode
    do_reset();
    thr = 40;
    pulse_start(1'b1);
    wait_end("t6a");
    chk("t6_div42", o_Clk_Div, 42);
    thr = 60;
    repeat (3) @(negedge clk);
    chk("t6_rearm_busy", o_Busy, 1);
    chk("t6_rearm_done", o_Done, 0);
    wait_end("t6b");
    chk("t6_done62", o_Done, 1);
    chk("t6_div62", o_Clk_Div, 62);
    thr = 253;
    repeat (3) @(negedge clk);
    wait_end("t6c");
    chk("t6_div_sat", o_Clk_Div, 254);
    chk("t6_done_sat", o_Done, 1);
    thr = 255;
    repeat (4) @(negedge clk);
    chk("t6_fail", o_Fail, 1);
    chk("t6_fail_done", o_Done, 0);
    chk("t6_fail_div", o_Clk_Div, 254);
    chk("t6_fail_busy", o_Busy, 0);

    // reset during OBSERVE of the first candidate
    do_reset();
    thr = 40;
    pulse_start(1'b0);
    n = 0;
    while (!o_Div_Update && n < 50) begin
      @(negedge clk); n++;
    end
    chk("t7_first_update", int'(n < 50), 1);
    repeat (10) @(negedge clk);
    chk("t7_mid_busy", o_Busy, 1);
    chk("t7_mid_div", o_Clk_Div, 127);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_div", o_Clk_Div, 128);
    chk("t7_rst_busy", o_Busy, 0);
    @(posedge clk); #1;
    chk("t7_rst_div2", o_Clk_Div, 128);
    chk("t7_rst_flags", {o_Div_Update, o_Done, o_Fail}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // extra starts while busy are ignored (mode stays one-shot)
    do_reset();
    thr = 40;
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    pulse_start(1'b1);
    repeat (20) @(negedge clk);
    pulse_start(1'b1);
    wait_end("t8");
    chk("t8_div", o_Clk_Div, 42);
    chk("t8_updates", upd_cnt, 8);
    thr = 60;
    repeat (6) @(negedge clk);
    chk("t8_oneshot_hold", o_Done, 1);
    chk("t8_oneshot_div", o_Clk_Div, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adaptive_clock_tuner.md
Name: adaptive_clock_tuner

Overview:
Successor clock-divider search engine. Performs a true binary search for the smallest divider that runs error-free for a programmable validation window. Applies a guard band to the result. Supports one-shot and continuous tracking modes, with an explicit start handshake and a failure indication. Sits between the error monitor (i_Error_Flag source) and the clock divider that consumes o_Clk_Div.

Parameters:
DATA_WIDTH, 8, width of divider value and search bounds
INITIAL_CLK_DIV, 128, divider driven out of reset and while idle
MIN_CLK_DIV, 1, lowest divider searched (must be >=1 and <=MAX_CLK_DIV)
MAX_CLK_DIV, 254, highest divider searched (must be <2^DATA_WIDTH)
SETTLE_CYCLES, 4, cycles after a divider change during which errors are ignored (>=1)
VALIDATION_CYCLES, 16, consecutive error-free cycles needed to pass a candidate (>=1)
GUARD_BAND, 2, margin added to the best passing divider; the sum saturates at MAX_CLK_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_Start  input  1  one-cycle pulse; starts a search from IDLE, ignored otherwise
i_Mode  input  1  0 = one-shot, 1 = tracking; sampled on accepted i_Start
i_Error_Flag  input  1  synchronous error indication from the monitor
o_Clk_Div  output  DATA_WIDTH  divider currently applied
o_Div_Update  output  1  one-cycle strobe whenever o_Clk_Div changes value
o_Busy  output  1  high from accepted start until DONE/FAIL entry
o_Done  output  1  high in DONE (search converged)
o_Fail  output  1  high in FAIL (no candidate passed)

Behaviour:
- Reset values: o_Clk_Div = INITIAL_CLK_DIV; all 1-bit outputs 0; state IDLE; Low = MIN_CLK_DIV; High = MAX_CLK_DIV; Best invalid; counters 0.
- States: IDLE, APPLY, SETTLE, OBSERVE, UPDATE, DONE, FAIL.
- IDLE: on i_Start, latch i_Mode, set Low = MIN and High = MAX, clear Best-valid, then go to APPLY.
- APPLY (1 cycle): Mid = (Low+High)>>1, computed in DATA_WIDTH+1 bits. o_Clk_Div <= Mid. o_Div_Update is pulsed if Mid differs from the old value. Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, ignoring i_Error_Flag, then go to OBSERVE with the pass counter at 0.
- OBSERVE:
  - Any cycle with i_Error_Flag=1 means the candidate fails. Go to UPDATE.
  - The candidate passes once VALIDATION_CYCLES consecutive flag=0 cycles are counted. Go to UPDATE.
  - The pass counter is sized clog2(VALIDATION_CYCLES+1) and never wraps.
- UPDATE (1 cycle):
  - On pass: Best = Mid, Best-valid = 1. If Mid == MIN, the search ends; otherwise High = Mid-1.
  - On fail: if Mid == MAX, the search ends; otherwise Low = Mid+1.
  - When the search ends, or Low > High after the update, go to finish. Otherwise return to APPLY.
- Finish:
  - If Best is valid: o_Clk_Div <= min(Best+GUARD_BAND, MAX), computed in DATA_WIDTH+1 bits. Go to DONE.
  - Otherwise: o_Clk_Div <= MAX. Go to FAIL.
  - In both cases o_Div_Update is pulsed if the value changed, and o_Busy drops in the same cycle.
- DONE:
  - In one-shot mode, DONE is held until reset.
  - In tracking mode, i_Error_Flag=1 while in DONE re-arms the search: Low = min(o_Clk_Div+1, MAX), High = MAX, Best-valid cleared, o_Done <= 0, o_Busy <= 1, go to APPLY.
  - If o_Clk_Div == MAX when the error arrives, go to FAIL instead.
- FAIL: held until reset. i_Start is ignored.
- i_Start while busy, in DONE, or in FAIL is ignored.
- An error arriving in the same cycle as the final pass count counts as a fail.
- Reset mid-search aborts immediately and restores the reset values above.
- Search length for defaults: at most 8 candidates. Each candidate takes 1 + SETTLE + up to VALIDATION + 1 cycles.

Test Plan:
- Bench model drives the error flag while o_Clk_Div < 40; defaults, mode 0, pulse i_Start -> o_Done=1, o_Clk_Div=42, o_Fail=0, o_Busy=0, at most 8 o_Div_Update pulses.
- Error model errs while o_Clk_Div < 255 (always) -> o_Fail=1, o_Done=0, o_Clk_Div=254.
- Error model never errs -> converges at Best=1, o_Clk_Div=3, o_Done=1.
- Tracking mode: converge at 42 with threshold 40, then raise threshold to 60 -> re-search over Low=43..254, o_Clk_Div=62, o_Done reasserts. Threshold 255 in DONE with o_Clk_Div=254 -> FAIL.
- Errors injected only during SETTLE windows with threshold 40 -> result unchanged at 42. A single error on the 16th observe cycle forces that candidate to fail.
- Assert rst_n in mid-OBSERVE -> next cycle o_Clk_Div=128 and all flags 0. Extra i_Start pulses while o_Busy=1 have no effect.
